// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter sequencing one registered access per grant into DataMemory.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_memWrite,
  output logic                  mem_memRead,
  input  logic [DATA_WIDTH-1:0] mem_readData
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic last_grant, win, win_n, we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic any_req;
  always_comb begin
    any_req = req0 | req1;
    // a tie goes to the port that did not win last time
    win_n = (req0 & req1) ? ~last_grant : req1;
    state_n = state;
    case (state)
      IDLE:    state_n = any_req ? ACCESS : IDLE;
      ACCESS:  state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        win     <= win_n;
        we_q    <= win_n ? we1 : we0;
        addr_q  <= win_n ? addr1 : addr0;
        wdata_q <= win_n ? wdata1 : wdata0;
      end
      if (state == ACCESS && !we_q) rdata <= mem_readData;
      if (state == DONE) last_grant <= win;
    end
  end
  assign busy          = state != IDLE;
  assign ack0          = state == DONE && !win;
  assign ack1          = state == DONE && win;
  assign mem_address   = state == ACCESS ? addr_q : '0;
  assign mem_writeData = state == ACCESS ? wdata_q : '0;
  assign mem_memWrite  = state == ACCESS && we_q;
  assign mem_memRead   = state == ACCESS && !we_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small DataMemory model.
module tb_dmem_arbiter;
  logic        Clk = 0, reset = 0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy, mem_memWrite, mem_memRead;
  logic [31:0] rdata, mem_address, mem_writeData, mem_readData;
  logic [31:0] dm [16];
  int n_pass = 0, n_total = 0;
  int k0, k1, s0, s1, max_w, nacks;
  logic [3:0] seq;
  logic ovl;

  dmem_arbiter dut (
    .Clk(Clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead), .mem_readData(mem_readData)
  );

  always #5 Clk = ~Clk;
  assign mem_readData = dm[mem_address[3:0]];
  always @(posedge Clk) if (mem_memWrite) dm[mem_address[3:0]] <= mem_writeData;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset held two cycles with both ports requesting
    req0 = 1; req1 = 1;
    tick; tick;
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_memwr", mem_memWrite, 0);
    check("rst_memrd", mem_memRead, 0);
    check("rst_addr", mem_address, 0);
    reset = 1; req0 = 0; req1 = 0;
    tick;
    // port 0 write e0000000 to 7
    req0 = 1; we0 = 1; addr0 = 7; wdata0 = 32'he0000000;
    check("wr_idle_memwr", mem_memWrite, 0);
    tick;
    check("wr_acc_memwr", mem_memWrite, 1);
    check("wr_acc_memrd", mem_memRead, 0);
    check("wr_acc_addr", mem_address, 7);
    check("wr_acc_data", mem_writeData, 32'he0000000);
    check("wr_acc_ack0", ack0, 0);
    check("wr_acc_busy", busy, 1);
    tick;
    check("wr_done_ack0", ack0, 1);
    check("wr_done_memwr", mem_memWrite, 0);
    check("wr_done_rdata", rdata, 0);
    req0 = 0; we0 = 0;
    tick;
    check("wr_idle_ack0", ack0, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_mem7", dm[7], 32'he0000000);
    // port 0 reads 7 back
    req0 = 1; addr0 = 7;
    tick;
    check("rd_acc_memrd", mem_memRead, 1);
    check("rd_acc_addr", mem_address, 7);
    tick;
    check("rd_done_ack0", ack0, 1);
    check("rd_done_rdata", rdata, 32'he0000000);
    req0 = 0;
    tick;
    // fresh reset so the first tie goes to port 0
    reset = 0; tick; reset = 1;
    req0 = 1; we0 = 1; addr0 = 6; wdata0 = 32'hffffffff;
    req1 = 1; we1 = 1; addr1 = 8; wdata1 = 32'haaaaaaaa;
    tick;
    check("tie1_c1_addr", mem_address, 6);
    check("tie1_c1_memwr", mem_memWrite, 1);
    tick;
    check("tie1_c2_ack0", ack0, 1);
    check("tie1_c2_ack1", ack1, 0);
    req0 = 0; we0 = 0;
    tick;
    check("tie1_c3_ack1", ack1, 0);
    check("tie1_c3_busy", busy, 0);
    tick;
    check("tie1_c4_addr", mem_address, 8);
    check("tie1_c4_data", mem_writeData, 32'haaaaaaaa);
    tick;
    check("tie1_c5_ack1", ack1, 1);
    check("tie1_c5_ack0", ack0, 0);
    req1 = 0; we1 = 0;
    tick;
    check("tie1_mem6", dm[6], 32'hffffffff);
    check("tie1_mem8", dm[8], 32'haaaaaaaa);
    // second tie: port 1 won last, so port 0 is eligible
    req0 = 1; addr0 = 8; req1 = 1; addr1 = 6;
    tick; tick;
    check("tie2_c2_ack0", ack0, 1);
    check("tie2_c2_rdata", rdata, 32'haaaaaaaa);
    req0 = 0;
    tick; tick; tick;
    check("tie2_c5_ack1", ack1, 1);
    check("tie2_c5_rdata", rdata, 32'hffffffff);
    req1 = 0;
    tick;
    // continuous contention: new read issued on every ack
    req0 = 1; addr0 = 6; req1 = 1; addr1 = 8;
    k0 = 0; k1 = 0; s0 = 0; s1 = 0; max_w = 0; nacks = 0; seq = 0; ovl = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_memRead && mem_memWrite) ovl = 1;
      if (ack0) begin
        check("cont_rd0", rdata, k0 == 0 ? 32'hffffffff : 32'he0000000);
        if (c - s0 > max_w) max_w = c - s0;
        k0++; s0 = c + 1; addr0 = 7; seq = {seq[2:0], 1'b0}; nacks++;
      end
      if (ack1) begin
        check("cont_rd1", rdata, k1 == 0 ? 32'haaaaaaaa : 32'hffffffff);
        if (c - s1 > max_w) max_w = c - s1;
        k1++; s1 = c + 1; addr1 = 6; seq = {seq[2:0], 1'b1}; nacks++;
      end
      tick;
    end
    check("cont_nacks", nacks, 4);
    check("cont_seq", seq, 4'b0101);
    check("cont_maxwait", max_w, 5);
    check("cont_overlap", ovl, 0);
    req0 = 0; req1 = 0;
    tick;
    // reset during ACCESS of a port 1 read of 6
    req1 = 1; addr1 = 6;
    tick;
    check("rstmid_memrd", mem_memRead, 1);
    check("rstmid_addr", mem_address, 6);
    reset = 0;
    tick;
    check("rstmid_ack1", ack1, 0);
    check("rstmid_rdata", rdata, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_memrd0", mem_memRead, 0);
    reset = 1; req1 = 0;
    tick;
    check("rstmid_noack", ack1, 0);
    req0 = 1; addr0 = 8;
    tick; tick;
    check("post_ack0", ack0, 1);
    check("post_rdata", rdata, 32'haaaaaaaa);
    req0 = 0;
    tick;
    // port 0 write data changes while port 1 is in flight
    req1 = 1; addr1 = 7;
    tick;
    req0 = 1; we0 = 1; addr0 = 9; wdata0 = 32'h11111111;
    tick;
    check("stale_ack1", ack1, 1);
    check("stale_rdata", rdata, 32'he0000000);
    req1 = 0; wdata0 = 32'h22222222;
    tick;
    check("stale_idle_busy", busy, 0);
    wdata0 = 32'h33333333;
    tick;
    wdata0 = 32'h44444444;
    check("stale_addr", mem_address, 9);
    check("stale_data", mem_writeData, 32'h33333333);
    tick;
    check("stale_ack0", ack0, 1);
    req0 = 0; we0 = 0;
    tick;
    check("stale_mem9", dm[9], 32'h33333333);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared `DataMemory`. It lets the CPU load/store stage (port 0) and a loader/debug requester (port 1) share the single memory port. Each port uses a req/ack handshake. Each granted access is registered and presented to memory for exactly one cycle, and the result is returned with a one-cycle ack. The block sits between the requesters and `DataMemory`, and its `mem_*` outputs connect directly to the memory's `address`, `writeData`, `memWrite`, `memRead` and `readData`.

## Interface
- `ADDR_WIDTH`, 32: address width, passed unchanged to memory.
- `DATA_WIDTH`, 32: data width.
- `Clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req0`/`req1` in 1: access request. Held high with stable address/data/write-enable until ack.
- `we0`/`we1` in 1: 1 = write, 0 = read.
- `addr0`/`addr1` in ADDR_WIDTH: request address, word index as memory uses it.
- `wdata0`/`wdata1` in DATA_WIDTH: write data.
- `ack0`/`ack1` out 1: one-cycle completion pulse.
- `rdata` out DATA_WIDTH: read result. Valid in the ack cycle and held until the next read completes.
- `busy` out 1: high in ACCESS and DONE.
- `mem_address` out ADDR_WIDTH, `mem_writeData` out DATA_WIDTH, `mem_memWrite` out 1, `mem_memRead` out 1: drive DataMemory.
- `mem_readData` in DATA_WIDTH: DataMemory read data, combinational from `mem_address`.

## Operation
- FSM states are IDLE, ACCESS and DONE. Encoding is free.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the port not granted last. The `last_grant` register resets to 1, so port 0 wins the first tie.
  - On grant: latch `we`, `addr`, `wdata` and the winner id; go to ACCESS.
- **ACCESS** (one cycle):
  - `mem_address` = latched address; `mem_writeData` = latched data; `mem_memWrite` = latched we; `mem_memRead` = !latched we.
  - On a read, capture `mem_readData` into `rdata` at the closing edge.
  - Go to DONE.
- **DONE** (one cycle):
  - `ack` of the winner is high; the other ack stays 0.
  - Update `last_grant` to the winner; go to IDLE.
- Outside ACCESS, all `mem_*` outputs are 0. `memWrite` and `memRead` are never high together.
- Writes leave `rdata` unchanged.
- Inputs are sampled only in IDLE. Changes on a waiting port while another access is in flight are ignored until the next IDLE.
- Starvation bound: a continuously requesting port is granted within 2 arbitration rounds, i.e. 6 cycles.

## Timing
- Reset (`reset`=0 at an edge):
  - State goes to IDLE; `last_grant`=1.
  - `ack0`=`ack1`=0, `rdata`=0, `busy`=0, all `mem_*`=0, starting from the cycle after that edge.
- Reset mid-ACCESS or mid-DONE: the in-flight access is abandoned with no ack. A write whose ACCESS cycle was already presented may have landed in memory.
- Latency, for a request seen in IDLE in cycle n:
  - Memory is driven in cycle n+1.
  - ack and `rdata` are valid in cycle n+2.
- Throughput is one access per 3 cycles.
- Handshake:
  - The requester samples ack at the edge ending DONE and deasserts or changes `req` at that same edge.
  - `req` still high in the following IDLE cycle is a new request.
- Simultaneous events:
  - A new request arriving during DONE is evaluated in the next IDLE.
  - Both ports requesting the same address are serialized in round-robin order. The second access sees the first one's write.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `req0`=`req1`=1 -> all outputs 0, no mem activity, no ack.
- **Single write then read:**
  - Port 0 writes 32'he0000000 to 7 -> `mem_memWrite`=1 with `mem_address`=7 for exactly one cycle; `ack0` 2 cycles after request.
  - Port 0 then reads 7 -> `rdata`=32'he0000000 with `ack0`.
- **Tie and round-robin:**
  - Port 0 writes 32'hffffffff to 6 while port 1 simultaneously writes 32'haaaaaaaa to 8 -> port 0 served first, `ack0` in cycle 2, `ack1` in cycle 5.
  - Next tie is won by whichever port `last_grant` makes eligible, in strict alternation.
- **Continuous contention:** both ports hold `req` with new reads every ack for 12 cycles -> acks alternate 0,1,0,1; no port waits more than 6 cycles; `memRead`/`memWrite` never overlap.
- **Reset mid-operation:** assert `reset`=0 during ACCESS of a port 1 read of address 6 -> no `ack1`, `rdata` cleared to 0, next request proceeds normally from IDLE.
- **Stale write data:** change `wdata0` while a port 1 access is in flight -> the port 0 write uses the value present in the IDLE cycle where it was granted.
